// File: rtl/data_register_file.sv
// Parametrised data store: one gated write port, two independent read ports,
// optional registered read with write-first bypass, and a clear sweep after reset.
module data_register_file #(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    ADDR_WIDTH   = 4,
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  is_instruction,
  input  logic [ADDR_WIDTH-1:0] load_address,
  input  logic [DATA_WIDTH-1:0] cpu_input,
  input  logic [ADDR_WIDTH-1:0] address_a,
  input  logic [ADDR_WIDTH-1:0] address_b,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] data_b,
  output logic                  ready,
  output logic                  load_drop
);

  localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic [ADDR_WIDTH-1:0] clr_ptr_next;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  data_req;
  logic                  we;
  logic                  drop_req;
  logic                  load_drop_q;

  // Instruction-bus traffic never touches this store; data loads only land once cleared.
  assign data_req  = load & ~is_instruction;
  assign we        = data_req & (state == READY);
  assign drop_req  = data_req & (state == CLEAR);
  assign ready     = (state == READY);
  assign load_drop = load_drop_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CLEAR;
      clr_ptr     <= '0;
      load_drop_q <= 1'b0;
    end else begin
      state       <= state_next;
      clr_ptr     <= clr_ptr_next;
      load_drop_q <= drop_req;
    end
  end

  // The pointer parks on the last address; the edge writing it also enters READY.
  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    case (state)
      CLEAR: begin
        if (clr_ptr == LAST_ADDR) begin
          state_next = READY;
        end else begin
          clr_ptr_next = clr_ptr + ADDR_WIDTH'(1);
        end
      end
      READY: begin
        state_next = READY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[clr_ptr] <= CLEAR_VALUE;
      end else if (we) begin
        mem[load_address] <= cpu_input;
      end
    end
  end

  // READ_LATENCY is 0 or 1; any non-zero value builds the registered path.
  generate
    if (READ_LATENCY == 0) begin : g_comb_read
      assign data_a = ready ? mem[address_a] : CLEAR_VALUE;
      assign data_b = ready ? mem[address_b] : CLEAR_VALUE;
    end else begin : g_reg_read
      logic [DATA_WIDTH-1:0] data_a_q;
      logic [DATA_WIDTH-1:0] data_b_q;

      // Write-first: a read hitting the address being written returns the new word.
      always_ff @(posedge clk) begin
        if (reset || state == CLEAR) begin
          data_a_q <= CLEAR_VALUE;
          data_b_q <= CLEAR_VALUE;
        end else begin
          data_a_q <= (we && load_address == address_a) ? cpu_input : mem[address_a];
          data_b_q <= (we && load_address == address_b) ? cpu_input : mem[address_b];
        end
      end

      assign data_a = data_a_q;
      assign data_b = data_b_q;
    end
  endgenerate

endmodule

// File: tb/tb_data_register_file.sv
// Directed bench: drives a registered-read and a combinational-read instance
// from the same stimulus and checks both against hand-computed values.
module tb_data_register_file;

  logic       clk;
  logic       reset;
  logic       load;
  logic       is_instruction;
  logic [3:0] load_address;
  logic [7:0] cpu_input;
  logic [3:0] address_a;
  logic [3:0] address_b;

  logic [7:0] data_a1, data_b1, data_a0, data_b0;
  logic       ready1, ready0, load_drop1, load_drop0;

  int check_count = 0;
  int pass_count  = 0;

  data_register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(1), .CLEAR_VALUE(8'h00)) dut1 (
    .clk(clk), .reset(reset), .load(load), .is_instruction(is_instruction),
    .load_address(load_address), .cpu_input(cpu_input),
    .address_a(address_a), .address_b(address_b),
    .data_a(data_a1), .data_b(data_b1), .ready(ready1), .load_drop(load_drop1)
  );

  data_register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(0), .CLEAR_VALUE(8'h00)) dut0 (
    .clk(clk), .reset(reset), .load(load), .is_instruction(is_instruction),
    .load_address(load_address), .cpu_input(cpu_input),
    .address_a(address_a), .address_b(address_b),
    .data_a(data_a0), .data_b(data_b0), .ready(ready0), .load_drop(load_drop0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic instr, input logic [3:0] laddr, input logic [7:0] din);
    load           = ld;
    is_instruction = instr;
    load_address   = laddr;
    cpu_input      = din;
  endtask

  // Advance one edge and settle just past it, away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 4'd0, 8'h00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rst_ready1", 32'(ready1), 32'd0);
    checkOutput("rst_ready0", 32'(ready0), 32'd0);
    checkOutput("rst_drop1", 32'(load_drop1), 32'd0);
    checkOutput("rst_data_a1", 32'(data_a1), 32'h00);
  endtask

  // Sixteen sweep edges; optional data load and instruction load on chosen edges.
  task automatic sweepAndCheck(input int write_edge, input int instr_edge);
    for (int e = 1; e <= 16; e++) begin
      if (e == write_edge)      applyStimulus(1'b1, 1'b0, 4'd2, 8'h11);
      else if (e == instr_edge) applyStimulus(1'b1, 1'b1, 4'd2, 8'h22);
      else                      applyStimulus(1'b0, 1'b0, 4'd0, 8'h00);
      tick();
      checkOutput($sformatf("sweep_ready1_e%0d", e), 32'(ready1), 32'(e == 16));
      checkOutput($sformatf("sweep_ready0_e%0d", e), 32'(ready0), 32'(e == 16));
      checkOutput($sformatf("sweep_drop1_e%0d", e), 32'(load_drop1), 32'(e == write_edge));
      checkOutput($sformatf("sweep_drop0_e%0d", e), 32'(load_drop0), 32'(e == write_edge));
      checkOutput($sformatf("sweep_data_a1_e%0d", e), 32'(data_a1), 32'h00);
      checkOutput($sformatf("sweep_data_a0_e%0d", e), 32'(data_a0), 32'h00);
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 8'h00);
  endtask

  initial begin
    reset     = 1'b1;
    address_a = 4'd0;
    address_b = 4'd0;
    applyStimulus(1'b0, 1'b0, 4'd0, 8'h00);
    tick();

    $display("[TB] reset sweep and cleared contents");
    doReset();
    sweepAndCheck(0, 0);
    for (int i = 0; i < 16; i++) begin
      address_a = 4'(i);
      #1;
      checkOutput($sformatf("clr_data_a0_%0d", i), 32'(data_a0), 32'h00);
      tick();
      checkOutput($sformatf("clr_data_a1_%0d", i), 32'(data_a1), 32'h00);
    end

    $display("[TB] write then read latency");
    address_a = 4'd0;
    applyStimulus(1'b1, 1'b0, 4'd3, 8'hA5);
    tick();
    checkOutput("wr_drop1", 32'(load_drop1), 32'd0);
    applyStimulus(1'b0, 1'b0, 4'd0, 8'h00);
    address_a = 4'd3;
    #1;
    checkOutput("wr_data_a0", 32'(data_a0), 32'hA5);
    checkOutput("wr_data_a1_before", 32'(data_a1), 32'h00);
    tick();
    checkOutput("wr_data_a1_after", 32'(data_a1), 32'hA5);

    $display("[TB] bypass and dual port");
    address_a = 4'd7;
    address_b = 4'd7;
    applyStimulus(1'b1, 1'b0, 4'd7, 8'h3C);
    #1;
    checkOutput("byp_old_a0", 32'(data_a0), 32'h00);
    checkOutput("byp_old_b0", 32'(data_b0), 32'h00);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 8'h00);
    checkOutput("byp_data_a1", 32'(data_a1), 32'h3C);
    checkOutput("byp_data_b1", 32'(data_b1), 32'h3C);
    checkOutput("byp_new_a0", 32'(data_a0), 32'h3C);
    address_a = 4'd3;
    address_b = 4'd7;
    tick();
    checkOutput("dual_a1", 32'(data_a1), 32'hA5);
    checkOutput("dual_b1", 32'(data_b1), 32'h3C);
    checkOutput("dual_a0", 32'(data_a0), 32'hA5);
    checkOutput("dual_b0", 32'(data_b0), 32'h3C);

    $display("[TB] instruction gating");
    address_a = 4'd5;
    applyStimulus(1'b1, 1'b1, 4'd5, 8'hFF);
    tick();
    checkOutput("instr_drop1", 32'(load_drop1), 32'd0);
    checkOutput("instr_drop0", 32'(load_drop0), 32'd0);
    applyStimulus(1'b0, 1'b0, 4'd0, 8'h00);
    tick();
    checkOutput("instr_data_a1", 32'(data_a1), 32'h00);
    checkOutput("instr_data_a0", 32'(data_a0), 32'h00);

    $display("[TB] write during sweep is dropped");
    address_a = 4'd2;
    address_b = 4'd2;
    doReset();
    sweepAndCheck(4, 6);
    tick();
    checkOutput("drop_data_a1", 32'(data_a1), 32'h00);
    checkOutput("drop_data_b0", 32'(data_b0), 32'h00);

    $display("[TB] reset mid-sweep");
    applyStimulus(1'b1, 1'b0, 4'd3, 8'hA5);
    tick();
    applyStimulus(1'b1, 1'b0, 4'd12, 8'h5A);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 8'h00);
    address_a = 4'd3;
    address_b = 4'd12;
    tick();
    checkOutput("pre_a1", 32'(data_a1), 32'hA5);
    checkOutput("pre_b1", 32'(data_b1), 32'h5A);
    checkOutput("pre_b0", 32'(data_b0), 32'h5A);
    doReset();
    for (int e = 1; e <= 8; e++) begin
      tick();
      checkOutput($sformatf("part_ready1_e%0d", e), 32'(ready1), 32'd0);
      checkOutput($sformatf("part_b0_e%0d", e), 32'(data_b0), 32'h00);
      checkOutput($sformatf("part_b1_e%0d", e), 32'(data_b1), 32'h00);
    end
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'd4, 8'h99);
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'd0, 8'h00);
    checkOutput("mid_drop1", 32'(load_drop1), 32'd0);
    checkOutput("mid_drop0", 32'(load_drop0), 32'd0);
    checkOutput("mid_ready1", 32'(ready1), 32'd0);
    checkOutput("mid_b0", 32'(data_b0), 32'h00);
    address_b = 4'd12;
    sweepAndCheck(0, 0);
    address_a = 4'd3;
    address_b = 4'd12;
    tick();
    checkOutput("post_a1", 32'(data_a1), 32'h00);
    checkOutput("post_b1", 32'(data_b1), 32'h00);
    checkOutput("post_a0", 32'(data_a0), 32'h00);
    checkOutput("post_b0", 32'(data_b0), 32'h00);
    address_a = 4'd4;
    #1;
    checkOutput("post_addr4_a0", 32'(data_a0), 32'h00);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
